// File: rtl/core_seq_ctrl_if.sv
// Handshake bundle between the host start logic, the core and core_seq_ctrl.
// master: the sequencer side; slave: the host/core side.
interface core_seq_ctrl_if;
  logic        start;
  logic        ofifo_valid;
  logic [34:0] inst;
  logic        busy;
  logic        out_valid;
  logic [3:0]  onij;
  logic        done;

  modport master (
    input  start,
    input  ofifo_valid,
    output inst,
    output busy,
    output out_valid,
    output onij,
    output done
  );

  modport slave (
    output start,
    output ofifo_valid,
    input  inst,
    input  busy,
    input  out_valid,
    input  onij,
    input  done
  );
endinterface

// File: rtl/core_seq_ctrl.sv
// Autonomous sequencer generating the core's 35-bit inst word for a full conv pass plus the
// pmem accumulation pass. CTRL_OFIFO_STREAM_EN drains the OFIFO concurrently with EXEC.
module core_seq_ctrl #(
  parameter int unsigned col      = 8,
  parameter int unsigned row      = 8,
  parameter int unsigned len_nij  = 36,
  parameter int unsigned len_kij  = 9,
  parameter int unsigned i_w      = 6,
  parameter int unsigned k_w      = 3,
  parameter logic [10:0] w_base   = 11'h400,
  parameter logic [10:0] act_base = 11'h000,
  parameter int unsigned gap_cyc  = 10
) (
  input logic            clk,
  input logic            reset,
  core_seq_ctrl_if.master bus
);

`ifdef CTRL_OFIFO_STREAM_EN
  localparam bit stream_en = 1'b1;
`else
  localparam bit stream_en = 1'b0;
`endif

  localparam int unsigned o_w   = i_w - k_w + 1;
  localparam int unsigned len_o = o_w * o_w;

  localparam logic [34:0] inst_idle = {1'b0, 1'b0, 1'b1, 1'b1, 11'd0, 1'b1, 1'b1, 11'd0, 7'd0};

  typedef enum logic [3:0] {
    StIdle, StWL0, StWLoad, StWGap, StAL0, StExec, StDrain, StORd, StAcc, StDone
  } state_e;

  state_e      state_q, state_d;
  logic [7:0]  cyc_q, cyc_d;
  logic [3:0]  kij_q, kij_d;
  logic [6:0]  rd_cnt_q, rd_cnt_d;
  logic [6:0]  wr_cnt_q, wr_cnt_d;
  logic        rd_issue_q;
  logic [3:0]  ki_q, ki_d, kj_q, kj_d;
  logic [3:0]  oi_q, oi_d, oj_q, oj_d;
  logic [3:0]  onij_cnt_q, onij_cnt_d;
  logic        kij_fin;

  logic        acc, cen_p, wen_p, cen_x, wen_x;
  logic [10:0] a_p, a_x;
  logic        ofifo_rd, l0_rd, l0_wr, execute, load;

  logic [34:0] inst_q, inst_d;
  logic        busy_q, busy_d;
  logic        out_valid_q, out_valid_d;
  logic        done_q, done_d;
  logic [3:0]  onij_out_q;

  always_comb begin
    state_d    = state_q;
    cyc_d      = cyc_q + 8'd1;
    kij_d      = kij_q;
    rd_cnt_d   = rd_cnt_q;
    wr_cnt_d   = wr_cnt_q;
    ki_d       = ki_q;
    kj_d       = kj_q;
    oi_d       = oi_q;
    oj_d       = oj_q;
    onij_cnt_d = onij_cnt_q;
    kij_fin    = 1'b0;

    acc      = 1'b0;
    cen_p    = 1'b1;
    wen_p    = 1'b1;
    a_p      = '0;
    cen_x    = 1'b1;
    wen_x    = 1'b1;
    a_x      = '0;
    ofifo_rd = 1'b0;
    l0_rd    = 1'b0;
    l0_wr    = 1'b0;
    execute  = 1'b0;
    load     = 1'b0;

    busy_d      = 1'b1;
    out_valid_d = 1'b0;
    done_d      = 1'b0;

    // An OFIFO read issued last cycle lands in pmem now, whichever state we are in.
    if (rd_issue_q) begin
      cen_p    = 1'b0;
      wen_p    = 1'b0;
      a_p      = 11'(32'(kij_q) * len_nij + 32'(wr_cnt_q));
      wr_cnt_d = wr_cnt_q + 7'd1;
    end

    unique case (state_q)
      StIdle: begin
        busy_d = 1'b0;
        cyc_d  = '0;
        if (bus.start) begin
          state_d    = StWL0;
          kij_d      = '0;
          onij_cnt_d = '0;
          rd_cnt_d   = '0;
          wr_cnt_d   = '0;
        end
      end
      StWL0: begin
        if (32'(cyc_q) < col) begin
          cen_x = 1'b0;
          a_x   = w_base + 11'(32'(kij_q) * col) + 11'(cyc_q);
        end
        if (cyc_q != '0) l0_wr = 1'b1;
        if (32'(cyc_q) == col) begin
          state_d = StWLoad;
          cyc_d   = '0;
        end
      end
      StWLoad: begin
        l0_rd = 1'b1;
        load  = 1'b1;
        if (32'(cyc_q) == col - 1) begin
          state_d = StWGap;
          cyc_d   = '0;
        end
      end
      StWGap: begin
        if (32'(cyc_q) == gap_cyc - 1) begin
          state_d = StAL0;
          cyc_d   = '0;
        end
      end
      StAL0: begin
        if (32'(cyc_q) < len_nij) begin
          cen_x = 1'b0;
          a_x   = act_base + 11'(cyc_q);
        end
        if (cyc_q != '0) l0_wr = 1'b1;
        if (32'(cyc_q) == len_nij) begin
          state_d = StExec;
          cyc_d   = '0;
        end
      end
      StExec: begin
        if (32'(cyc_q) < len_nij) begin
          execute = 1'b1;
          l0_rd   = 1'b1;
        end
        if (stream_en && bus.ofifo_valid && 32'(rd_cnt_q) < len_nij) begin
          ofifo_rd = 1'b1;
          rd_cnt_d = rd_cnt_q + 7'd1;
        end
        if (32'(cyc_q) == len_nij + row + col - 1) begin
          state_d = StDrain;
          cyc_d   = '0;
        end
      end
      StDrain: begin
        cyc_d = '0;
        if (stream_en && 32'(wr_cnt_d) == len_nij) begin
          kij_fin = 1'b1;
        end else if (bus.ofifo_valid && 32'(rd_cnt_q) < len_nij) begin
          state_d = StORd;
        end
      end
      StORd: begin
        if (32'(rd_cnt_q) < len_nij && (bus.ofifo_valid || !stream_en)) begin
          ofifo_rd = 1'b1;
          rd_cnt_d = rd_cnt_q + 7'd1;
        end
        if (32'(wr_cnt_d) == len_nij) kij_fin = 1'b1;
      end
      StAcc: begin
        // cyc_q doubles as the kij index of the psum being read.
        if (32'(cyc_q) < len_kij) begin
          cen_p = 1'b0;
          a_p   = 11'(32'(cyc_q) * len_nij + (32'(oi_q) + 32'(ki_q)) * i_w
                      + 32'(oj_q) + 32'(kj_q));
          if (32'(kj_q) == k_w - 1) begin
            kj_d = '0;
            ki_d = ki_q + 4'd1;
          end else begin
            kj_d = kj_q + 4'd1;
          end
        end
        if (cyc_q != '0 && 32'(cyc_q) <= len_kij) acc = 1'b1;
        if (32'(cyc_q) == len_kij + 1) begin
          out_valid_d = 1'b1;
          cyc_d       = '0;
          ki_d        = '0;
          kj_d        = '0;
          if (32'(onij_cnt_q) == len_o - 1) begin
            state_d = StDone;
          end else begin
            onij_cnt_d = onij_cnt_q + 4'd1;
            if (32'(oj_q) == o_w - 1) begin
              oj_d = '0;
              oi_d = oi_q + 4'd1;
            end else begin
              oj_d = oj_q + 4'd1;
            end
          end
        end
      end
      StDone: begin
        busy_d  = 1'b0;
        done_d  = 1'b1;
        cyc_d   = '0;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase

    if (kij_fin) begin
      cyc_d    = '0;
      rd_cnt_d = '0;
      wr_cnt_d = '0;
      if (32'(kij_q) == len_kij - 1) begin
        state_d    = StAcc;
        ki_d       = '0;
        kj_d       = '0;
        oi_d       = '0;
        oj_d       = '0;
        onij_cnt_d = '0;
      end else begin
        state_d = StWL0;
        kij_d   = kij_q + 4'd1;
      end
    end

    inst_d = {1'b0, acc, cen_p, wen_p, a_p, cen_x, wen_x, a_x,
              ofifo_rd, 1'b0, 1'b0, l0_rd, l0_wr, execute, load};
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= StIdle;
      cyc_q       <= '0;
      kij_q       <= '0;
      rd_cnt_q    <= '0;
      wr_cnt_q    <= '0;
      rd_issue_q  <= 1'b0;
      ki_q        <= '0;
      kj_q        <= '0;
      oi_q        <= '0;
      oj_q        <= '0;
      onij_cnt_q  <= '0;
      inst_q      <= inst_idle;
      busy_q      <= 1'b0;
      out_valid_q <= 1'b0;
      done_q      <= 1'b0;
      onij_out_q  <= '0;
    end else begin
      state_q     <= state_d;
      cyc_q       <= cyc_d;
      kij_q       <= kij_d;
      rd_cnt_q    <= rd_cnt_d;
      wr_cnt_q    <= wr_cnt_d;
      rd_issue_q  <= ofifo_rd;
      ki_q        <= ki_d;
      kj_q        <= kj_d;
      oi_q        <= oi_d;
      oj_q        <= oj_d;
      onij_cnt_q  <= onij_cnt_d;
      inst_q      <= inst_d;
      busy_q      <= busy_d;
      out_valid_q <= out_valid_d;
      done_q      <= done_d;
      if (out_valid_d) onij_out_q <= onij_cnt_q;
    end
  end

  assign bus.inst      = inst_q;
  assign bus.busy      = busy_q;
  assign bus.out_valid = out_valid_q;
  assign bus.onij      = onij_out_q;
  assign bus.done      = done_q;

endmodule
